exec_completion_queue: RTL

EXEC_COMPLETION_QUEUE -- requirements
Module: exec_completion_queue

---
 rtl/exec_completion_queue.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/exec_completion_queue.sv
// In-order completion queue between decode and retire: issues to one-hot units, collects
// out-of-order unit completions, retires in program order. Optional bypass: EXEC_BYPASS_EN.
module exec_completion_queue #(
  parameter int N_UNITS = 4,
  parameter int DEPTH   = 4,
  parameter int XLEN    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_UNITS-1:0]   in_unit,
  input  logic [4:0]           in_rd,
  input  logic                 in_reg_write,
  input  logic                 in_exception,
  input  logic [3:0]           in_cause,
  output logic [N_UNITS-1:0]   unit_issue,
  input  logic [N_UNITS-1:0]   unit_done,
  input  logic [N_UNITS*XLEN-1:0] unit_result,
  input  logic [N_UNITS-1:0]   unit_exception,
  input  logic [N_UNITS*4-1:0] unit_cause,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           out_rd,
  output logic                 out_reg_write,
  output logic [XLEN-1:0]      out_result,
  output logic                 out_exception,
  output logic [3:0]           out_cause,
  input  logic                 flush,
  input  logic [4:0]           byp_rs1,
  input  logic [4:0]           byp_rs2,
  output logic                 byp_rs1_hit,
  output logic                 byp_rs2_hit,
  output logic [XLEN-1:0]      byp_rs1_data,
  output logic [XLEN-1:0]      byp_rs2_data,
  output logic                 byp_stall
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [N_UNITS-1:0] ent_unit   [DEPTH];
  logic [4:0]         ent_rd     [DEPTH];
  logic [3:0]         ent_cause  [DEPTH];
  logic [XLEN-1:0]    ent_result [DEPTH];
  logic [DEPTH-1:0]   ent_wr;
  logic [DEPTH-1:0]   ent_exc;
  logic [DEPTH-1:0]   ent_done;
  logic [DEPTH-1:0]   ent_valid;

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          push, pop;

  logic [N_UNITS-1:0] comp_found, comp_fire;
  logic [PW-1:0]      comp_idx [N_UNITS];

  // Validity is derived from age relative to head, so flush/reset only touch pointers.
  always_comb begin
    logic [PW-1:0] age;
    // NOTE: every always_comb output gets a default before any conditional logic, so no latch is inferred.
    ent_valid = '0;
    age       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age          = PW'(i) - head;
      ent_valid[i] = ({1'b0, age} < count);
    end
  end

  assign in_ready   = !rst && !flush && (count < CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign unit_issue = (push && !in_exception) ? in_unit : '0;

  assign out_valid     = !rst && ent_valid[head] && ent_done[head];
  assign pop           = out_valid && out_ready;
  assign out_rd        = ent_rd[head];
  assign out_reg_write = ent_wr[head] && (ent_rd[head] != 5'd0);
  assign out_result    = ent_result[head];
  assign out_exception = ent_exc[head];
  assign out_cause     = ent_cause[head];

  // Each unit finishes in order, so its completion belongs to its oldest pending entry.
  always_comb begin
    logic [PW-1:0] cidx;
    comp_found = '0;
    cidx       = '0;
    for (int u = 0; u < N_UNITS; u++) begin
      comp_idx[u] = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        cidx = head + PW'(k);
        if (ent_valid[cidx] && !ent_done[cidx] && ent_unit[cidx][u]) begin
          comp_found[u] = 1'b1;
          comp_idx[u]   = cidx;
        end
      end
    end
  end

  assign comp_fire = comp_found & unit_done & {N_UNITS{!flush}};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      ent_done <= '0;
    end else begin
      if (push) begin
        tail           <= tail + PW'(1);
        ent_done[tail] <= in_exception;
      end
      if (pop) head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      for (int u = 0; u < N_UNITS; u++)
        if (comp_fire[u]) ent_done[comp_idx[u]] <= 1'b1;
    end
  end

  // NOTE: payload storage has no reset; done bits plus count decide what is meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_unit[tail]   <= in_unit;
      ent_rd[tail]     <= in_rd;
      ent_wr[tail]     <= in_reg_write;
      ent_exc[tail]    <= in_exception;
      ent_cause[tail]  <= in_exception ? in_cause : 4'd0;
      ent_result[tail] <= '0;
    end
    for (int u = 0; u < N_UNITS; u++) begin
      if (comp_fire[u]) begin
        ent_result[comp_idx[u]] <= unit_result[u*XLEN +: XLEN];
        ent_exc[comp_idx[u]]    <= unit_exception[u];
        ent_cause[comp_idx[u]]  <= unit_cause[u*4 +: 4];
      end
    end
  end

  // Scan oldest to youngest so the youngest matching producer wins.
  logic m1, m2;
`ifdef EXEC_BYPASS_EN
  logic m1_done, m2_done;
  logic [XLEN-1:0] m1_data, m2_data;
`endif

  always_comb begin
    logic [PW-1:0] bidx;
    m1   = 1'b0;
    m2   = 1'b0;
    bidx = '0;
`ifdef EXEC_BYPASS_EN
    m1_done = 1'b0;
    m2_done = 1'b0;
    m1_data = '0;
    m2_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      bidx = head + PW'(k);
      if (ent_valid[bidx] && ent_wr[bidx]) begin
        if (byp_rs1 != 5'd0 && ent_rd[bidx] == byp_rs1) begin
          m1 = 1'b1;
`ifdef EXEC_BYPASS_EN
          m1_done = ent_done[bidx];
          m1_data = ent_result[bidx];
`endif
        end
        if (byp_rs2 != 5'd0 && ent_rd[bidx] == byp_rs2) begin
          m2 = 1'b1;
`ifdef EXEC_BYPASS_EN
          m2_done = ent_done[bidx];
          m2_data = ent_result[bidx];
`endif
        end
      end
    end
  end

`ifdef EXEC_BYPASS_EN
  assign byp_rs1_hit  = !rst && m1 && m1_done;
  assign byp_rs2_hit  = !rst && m2 && m2_done;
  assign byp_rs1_data = (m1 && m1_done) ? m1_data : '0;
  assign byp_rs2_data = (m2 && m2_done) ? m2_data : '0;
  assign byp_stall    = !rst && ((m1 && !m1_done) || (m2 && !m2_done));
`else
  assign byp_rs1_hit  = 1'b0;
  assign byp_rs2_hit  = 1'b0;
  assign byp_rs1_data = '0;
  assign byp_rs2_data = '0;
  assign byp_stall    = !rst && (m1 || m2);
`endif

endmodule
